sar_search: RTL
===============

SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter WIDTH, default 16: operand / candidate width in bits.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles to wait for a comparator response per candidate.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new search; sampled only in IDLE.
REQ-006 cand  output  WIDTH  candidate word driven to the external magnitude comparator (B operand; A operand is the hidden target).
REQ-007 cand_valid  output  1  cand is valid and awaiting a comparator response.
REQ-008 cmp_valid  input  1  comparator response valid for the current cand.
REQ-009 cmp_gt, cmp_lt, cmp_eq  input  1 each  target > cand, target < cand, target == cand.
REQ-010 busy  output  1  search in progress (any state other than IDLE).
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 result  output  WIDTH  converged value.
REQ-013 found  output  1  an exact-equality response was received during the search.
REQ-014 err  output  1  search aborted on protocol error or timeout.
REQ-015 steps  output  $clog2(WIDTH)+1  count of accepted comparator responses in the last search.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT and DONE.
REQ-017 IDLE with start=1 SHALL perform the following on the next edge: result<=0, found<=0, err<=0, steps<=0, bit index k<=WIDTH-1, cand<=1<<(WIDTH-1), cand_valid<=1, timeout counter<=0, go to WAIT.
REQ-018 In IDLE with start=0, all registers SHALL hold their values; result, found, err and steps SHALL stay stable until the next accepted start.
REQ-019 In WAIT, cand SHALL be held stable while cand_valid=1 until a response is accepted.
REQ-020 A response SHALL be accepted on any WAIT cycle with cmp_valid=1, including the first cycle cand_valid is high (zero-latency comparator allowed); steps SHALL increment by 1 on each accepted response.
REQ-021 A valid response SHALL have exactly one of cmp_gt, cmp_lt and cmp_eq asserted; any other combination with cmp_valid=1 SHALL set err<=1, cand_valid<=0 and go to DONE.
REQ-022 On cmp_eq: result<=cand, found<=1, cand_valid<=0, go to DONE (early termination).
REQ-023 On cmp_gt: result<=cand (bit k kept). On cmp_lt: result unchanged (bit k cleared).
REQ-024 After cmp_gt or cmp_lt with k==0: cand_valid<=0, go to DONE.
REQ-025 After cmp_gt or cmp_lt with k>0: k<=k-1, cand<=new result | (1<<(k-1)), cand_valid stays 1, timeout counter<=0, remain in WAIT (back-to-back candidates, no idle cycle).
REQ-026 The timeout counter SHALL increment on each WAIT cycle with cmp_valid=0.
REQ-027 When the timeout counter reaches TIMEOUT, the block SHALL set err<=1, cand_valid<=0 and go to DONE; result SHALL keep its partial value.
REQ-028 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-029 busy SHALL be 1 in WAIT and DONE.
REQ-030 start asserted while busy SHALL be ignored.
REQ-031 cmp_valid received outside WAIT SHALL be ignored.
REQ-032 Latency: with a zero-latency comparator, done SHALL assert exactly N+1 cycles after the start edge, where N is the number of accepted responses (N≤WIDTH).
REQ-033 A target of 0 SHALL produce WIDTH lt responses, result=0 and found=0. A full search without an eq response SHALL yield result equal to the target and found=0; this occurs only when target=0.

Reset
REQ-034 With rst_n=0, immediately and regardless of the clock: state=IDLE, cand=0, cand_valid=0, busy=0, done=0, result=0, found=0, err=0, steps=0, k=0, timeout counter=0.
REQ-035 Reset asserted mid-search SHALL abandon the search with no done pulse.
REQ-036 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-037 Target 0xA5C3, ideal zero-latency comparator, start pulse -> 16 responses, eq on the 16th (cand=0xA5C3), done at cycle 17, result=0xA5C3, found=1, steps=16, err=0.
REQ-038 Target 0x8000 -> eq on the first cand (0x8000), done 2 cycles after start, result=0x8000, found=1, steps=1.
REQ-039 Target 0x0000 -> 16 lt responses, result=0x0000, found=0, steps=16, err=0.
REQ-040 Comparator with a 3-cycle response delay and target 0x1234 -> cand held stable during each wait, result=0x1234, found=1, done asserted after the final response.
REQ-041 Second response returns cmp_gt=1 and cmp_lt=1 -> err=1, done pulse, steps=2, cand_valid=0. Separately, cmp_valid held low for 255 cycles -> err=1, done, result=0.
REQ-042 rst_n pulsed low during the 5th candidate wait -> all outputs 0 immediately, no done pulse; a new start then completes a normal search.

Source files
------------

// File: rtl/sar_search.sv
// Successive-approximation search against an external magnitude comparator.
// Drives one candidate per response (MSB first), stops early on equality, aborts on bad or missing responses.
module sar_search #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255,
    localparam int KW     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int SW     = $clog2(WIDTH) + 1,
    localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic [WIDTH-1:0] cand_o,
    output logic             cand_valid_o,
    input  logic             cmp_valid_i,
    input  logic             cmp_gt_i,
    input  logic             cmp_lt_i,
    input  logic             cmp_eq_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             found_o,
    output logic             err_o,
    output logic [SW-1:0]    steps_o
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] cand_q, result_q;
    logic             cand_valid_q, found_q, err_q;
    logic [SW-1:0]    steps_q;
    logic [KW-1:0]    k_q;
    logic [TW-1:0]    tmo_q;

    logic [2:0]       flags;
    logic             one_hot;
    logic [WIDTH-1:0] res_d, cand_d;

    assign flags   = {cmp_gt_i, cmp_lt_i, cmp_eq_i};
    assign one_hot = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
    // gt keeps the trial bit (result takes the candidate); lt drops it
    assign res_d   = cmp_gt_i ? cand_q : result_q;
    assign cand_d  = res_d | (WIDTH'(1) << (k_q - KW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cand_q       <= '0;
            cand_valid_q <= 1'b0;
            result_q     <= '0;
            found_q      <= 1'b0;
            err_q        <= 1'b0;
            steps_q      <= '0;
            k_q          <= '0;
            tmo_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    result_q     <= '0;
                    found_q      <= 1'b0;
                    err_q        <= 1'b0;
                    steps_q      <= '0;
                    k_q          <= KW'(WIDTH - 1);
                    cand_q       <= {1'b1, {(WIDTH-1){1'b0}}};
                    cand_valid_q <= 1'b1;
                    tmo_q        <= '0;
                    state_q      <= WAIT;
                end
                WAIT: if (cmp_valid_i) begin
                    steps_q <= steps_q + SW'(1);
                    tmo_q   <= '0;
                    if (!one_hot) begin
                        err_q        <= 1'b1;
                        cand_valid_q <= 1'b0;
                        state_q      <= DONE;
                    end else if (cmp_eq_i) begin
                        result_q     <= cand_q;
                        found_q      <= 1'b1;
                        cand_valid_q <= 1'b0;
                        state_q      <= DONE;
                    end else begin
                        result_q <= res_d;
                        if (k_q == '0) begin
                            cand_valid_q <= 1'b0;
                            state_q      <= DONE;
                        end else begin
                            k_q    <= k_q - KW'(1);
                            cand_q <= cand_d;
                        end
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // TIMEOUT silent cycles for one candidate: give up, keep partial result
                    err_q        <= 1'b1;
                    cand_valid_q <= 1'b0;
                    state_q      <= DONE;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cand_o       = cand_q;
    assign cand_valid_o = cand_valid_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign result_o     = result_q;
    assign found_o      = found_q;
    assign err_o        = err_q;
    assign steps_o      = steps_q;

endmodule
